// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage multi-cycle divide sequencer.
package div_seq_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_seq_step.sv
// One combinational radix-2 restoring division iteration.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so the W+1-bit difference cannot wrap and its MSB is the sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer: stalls the pipeline while an iterative restoring divider runs.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall,
  output logic             ready,
  output logic             hl_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             qsign, rsign;
  logic             go, last;

  assign go    = start & ~annul;
  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign abs_a = (signed_div & opa[WIDTH-1]) ? WIDTH'(-opa) : opa;
  assign abs_b = (signed_div & opb[WIDTH-1]) ? WIDTH'(-opb) : opb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        stall = go;
        if (go) state_next = (opb == '0) ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        ready      = ~annul;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (annul) state_next = IDLE;
  end

  assign hl_we = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            if (opb != '0) begin
              quo   <= abs_a;
              dvs   <= abs_b;
              rem   <= '0;
              cnt   <= '0;
              qsign <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
              rsign <= signed_div & opa[WIDTH-1];
            end else begin
              lo <= '1;
              hi <= opa;
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              lo <= qsign ? WIDTH'(-quo_n) : quo_n;
              hi <= rsign ? WIDTH'(-rem_n) : rem_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for DIV/DIVU in the EX stage, containing an iterative radix-2 restoring divider datapath.
- Captures operands when the main decoder's DIV/DIVU path asserts start, and holds the pipeline with a stall signal while iterating.
- On completion, delivers {HI, LO} with a single-cycle HI/LO write-enable pulse.
- An annul input cancels an in-flight division on flush or exception.

Parameters:
- WIDTH, 32, operand/quotient/remainder width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  DIV/DIVU present in EX and valid; level, held by the stall.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opa  in  WIDTH  dividend (rs); sampled with start.
- opb  in  WIDTH  divisor (rt); sampled with start.
- annul  in  1  cancel current or pending division.
- stall  out  1  freeze IF/ID/EX while the division is outstanding.
- ready  out  1  result valid this cycle.
- hl_we  out  1  HI/LO write enable; equals ready.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.

Behaviour:
- Reset: state IDLE, counter 0, hi = 0, lo = 0, ready = 0, hl_we = 0, stall = 0. Reset mid-operation abandons the division with no write.
- State IDLE:
  - start & !annul & opb != 0: latch |opa|, |opb| (absolute value only if signed_div), quotient-sign = opa[MSB]^opb[MSB], remainder-sign = opa[MSB] (both signs forced to 0 when unsigned); clear partial remainder and counter; go to BUSY.
  - start & !annul & opb == 0: load lo = all ones, hi = opa; go to DONE.
- State BUSY, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem at WIDTH+1 bits.
  - If non-negative, keep the difference and set the quo LSB.
  - Counter increments; after step WIDTH (counter == WIDTH-1 at the edge), apply sign fix-up (negate quotient/remainder per latched signs, WIDTH-bit wrap) into lo/hi; go to DONE.
- State DONE: ready = hl_we = 1 for exactly one cycle, stall = 0; unconditionally return to IDLE. A start seen in DONE is ignored because it belongs to the instruction already retiring.
- stall (combinational) = (IDLE & start & !annul) | BUSY.
- Latency: start sampled at cycle 0 gives BUSY for cycles 1..32 and DONE at cycle 33, so stall is high on cycles 0..32. Divide-by-zero gives DONE at cycle 1, with stall high on cycle 0 only.
- annul: in any state, next state is IDLE; ready/hl_we are not asserted and hi/lo keep prior values. annul during DONE suppresses hl_we that cycle. annul overrides start in the same cycle.
- Overflow case 0x80000000 / -1 (signed): quotient wraps to 0x80000000, remainder 0; no trap.
- Operands may change while stall is high; only the latched copies are used.
- hi/lo hold their values between divisions.

Decomposition:
- Shared package (with the existing opcode/funct defines): state encoding IDLE/BUSY/DONE, DIV_WIDTH = 32, DIV_LATENCY = 33.
- One sub-module: div_step, a combinational single restoring iteration. Inputs: rem, quo, divisor. Outputs: next rem, next quo. Reused if the step is later unrolled to radix-4.

Test Plan:
- DIVU 100/7: start at cycle 0 → stall cycles 0..32; ready/hl_we at cycle 33 with lo = 14, hi = 2; stall low at cycle 33.
- DIV -7/2 (opa = 0xFFFFFFF9, opb = 2): lo = 0xFFFFFFFD, hi = 0xFFFFFFFF at cycle 33. DIVU on the same operands: lo = 0x7FFFFFFC, hi = 1.
- DIV/DIVU 5/0: DONE at cycle 1 with lo = 0xFFFFFFFF, hi = 5; stall high only on cycle 0.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 at cycle 33. DIVU 0xFFFFFFFF/1: lo = 0xFFFFFFFF, hi = 0.
- annul at cycle 10 of a 100/7 division → IDLE at cycle 11; no hl_we; hi/lo unchanged; stall low once start drops. Repeat with annul in DONE → hl_we stays 0.
- Back-to-back DIVU 9/4 then 20/3 (second start right after DONE) → hl_we at cycle 33 with hi = 1, lo = 2; then hl_we 34 cycles later with hi = 2, lo = 6. rst asserted at BUSY cycle 5 → all outputs 0 next cycle, no hl_we.
